// File: rtl/nios2_ram_bist_master.sv
// nios2_ram_bist_master
//   Avalon-MM master that fills a word range of the on-chip RAM with an
//   additive pattern, reads it back, compares every word, and reports the
//   result together with the first failing address and the data read there.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               one-cycle command strobe (ignored unless idle)
//   base_addr           first word address, sampled on start
//   word_count          number of words, sampled on start
//   seed                first pattern word, sampled on start
//   busy / done         run in progress / one-cycle completion pulse
//   pass                result, valid from done until the next accepted start
//   fail_addr/fail_data first mismatching address and the data read there
//   av_*                Avalon-MM master port towards the RAM s1 slave
module nios2_ram_bist_master #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] PAT_STEP     = 32'h9E3779B9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_data,
    output logic [ADDR_W-1:0]   av_address,
    output logic                av_chipselect,
    output logic                av_read,
    output logic                av_write,
    output logic [DATA_W/8-1:0] av_byteenable,
    output logic [DATA_W-1:0]   av_writedata,
    input  logic [DATA_W-1:0]   av_readdata,
    input  logic                av_waitrequest
);

    localparam logic [DATA_W-1:0] STEP     = DATA_W'(PAT_STEP);
    localparam logic [2:0]        LAT_INIT = 3'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_WAIT,
        FINISH
    } state_t;

    state_t              state_q,     state_d;
    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    logic [ADDR_W-1:0]   base_q,      base_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   seed_q,      seed_d;
    logic [DATA_W-1:0]   pat_q,       pat_d;
    logic [15:0]         count_q,     count_d;
    logic [15:0]         idx_q,       idx_d;
    logic [2:0]          lat_q,       lat_d;
    logic                pass_q,      pass_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_data_q, fail_data_d;
    logic                last_word;

    // Reset asserts asynchronously but releases two clocks after reset_n
    // rises, so no flop sees a release edge close to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            seed_q      <= '0;
            pat_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            pat_q       <= pat_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign last_word = (idx_q == (count_q - 16'd1));

    // addr_q and pat_q track word i directly (base+i, seed+i*STEP) so the
    // bus outputs come straight from flops and no adder or multiplier sits
    // in the address/data path.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        pat_d       = pat_q;
        count_d     = count_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    addr_d  = base_addr;
                    seed_d  = seed;
                    pat_d   = seed;
                    count_d = word_count;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    if (word_count == 16'd0) begin
                        pass_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!av_waitrequest) begin
                    if (last_word) begin
                        idx_d   = '0;
                        addr_d  = base_q;
                        pat_d   = seed_q;
                        state_d = RD_REQ;
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        addr_d = addr_q + 1'b1;
                        pat_d  = pat_q + STEP;
                    end
                end
            end
            RD_REQ: begin
                if (!av_waitrequest) begin
                    lat_d   = LAT_INIT;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == 3'd1) begin
                    if (av_readdata != pat_q) begin
                        fail_addr_d = addr_q;
                        fail_data_d = av_readdata;
                        pass_d      = 1'b0;
                        state_d     = FINISH;
                    end else if (last_word) begin
                        pass_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        addr_d  = addr_q + 1'b1;
                        pat_d   = pat_q + STEP;
                        state_d = RD_REQ;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so they fall as soon
    // as reset clears it, without waiting for a clock edge.
    always_comb begin
        av_write      = (state_q == WRITE);
        av_read       = (state_q == RD_REQ);
        av_chipselect = av_write | av_read;
        busy          = (state_q == WRITE) || (state_q == RD_REQ) ||
                        (state_q == RD_WAIT);
        done          = (state_q == FINISH);
    end

    assign av_byteenable = '1;
    assign av_address    = addr_q;
    assign av_writedata  = pat_q;
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_data     = fail_data_q;

endmodule
